srcopr_wakeup_buffer: RTL and testbench

Operand storage and wakeup for one reservation-station group. It accepts dispatched instructions whose sources have already been resolved at rename: each source is either a value or an RRF tag plus a ready bit. It snoops NUM_BCAST result broadcast buses and captures data into waiting operands. It reports per-entry readiness to the issue selector and returns the operands of an issued entry one cycle later.

---
 rtl/srcopr_wakeup_buffer_pkg.sv | 24 ++
 rtl/srcopr_wakeup_slot.sv | 63 ++++++
 rtl/srcopr_wakeup_buffer.sv | 118 +++++++++++
 tb/tb_srcopr_wakeup_buffer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/srcopr_wakeup_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module : srcopr_wakeup_buffer_pkg
// Brief  : Shared operand/tag widths and reservation-station group defaults.
// Rev    : 1.0
// ============================================================================
package srcopr_wakeup_buffer_pkg;

   localparam int DATA_LEN     = 32;
   localparam int RRF_SEL      = 6;

   localparam int RS_ENTRY_NUM = 8;
   localparam int RS_ENTRY_SEL = 3;
   localparam int RS_NUM_SRC   = 2;
   localparam int RS_NUM_BCAST = 4;

   // Field holds the RRF tag in its low bits until rdy is set, then the value.
   typedef struct packed {
      logic                rdy;
      logic [DATA_LEN-1:0] data;
   } operand_t;

endpackage : srcopr_wakeup_buffer_pkg
`default_nettype wire

// File: rtl/srcopr_wakeup_slot.sv
`default_nettype none
// ============================================================================
// Module : srcopr_wakeup_slot
// Brief  : One source operand: tag snoop, lowest-bus-wins capture, write bypass.
// Rev    : 1.0
// ============================================================================
module srcopr_wakeup_slot
   import srcopr_wakeup_buffer_pkg::*;
#(
   parameter int NUM_BCAST = RS_NUM_BCAST
) (
   input  logic                          clk_i,
   input  logic                          busy_i,
   input  logic                          we_i,
   input  logic [DATA_LEN-1:0]           wdata_i,
   input  logic                          wrdy_i,
   input  logic [NUM_BCAST-1:0]          bcast_valid_i,
   input  logic [NUM_BCAST*RRF_SEL-1:0]  bcast_tag_i,
   input  logic [NUM_BCAST*DATA_LEN-1:0] bcast_data_i,
   output operand_t                      opr_o
);

   operand_t            opr_q;
   operand_t            opr_d;
   logic [RRF_SEL-1:0]  w_tag;
   logic                w_hit;
   logic [DATA_LEN-1:0] w_hit_data;

   // During a write the incoming tag is snooped so a same-cycle result is not lost.
   always_comb begin
      w_tag = we_i ? wdata_i[RRF_SEL-1:0] : opr_q.data[RRF_SEL-1:0];
   end

   always_comb begin
      w_hit      = 1'b0;
      w_hit_data = '0;
      for (int k = NUM_BCAST - 1; k >= 0; k--) begin
         if (bcast_valid_i[k] && (bcast_tag_i[k*RRF_SEL +: RRF_SEL] == w_tag)) begin
            w_hit      = 1'b1;
            w_hit_data = bcast_data_i[k*DATA_LEN +: DATA_LEN];
         end
      end
   end

   always_comb begin
      opr_d = opr_q;
      if (we_i) begin
         opr_d.rdy  = wrdy_i | w_hit;
         opr_d.data = (!wrdy_i && w_hit) ? w_hit_data : wdata_i;
      end else if (busy_i && !opr_q.rdy && w_hit) begin
         opr_d.rdy  = 1'b1;
         opr_d.data = w_hit_data;
      end
   end

   always_ff @(posedge clk_i) begin
      opr_q <= opr_d;
   end

   assign opr_o = opr_q;

endmodule : srcopr_wakeup_slot
`default_nettype wire

// File: rtl/srcopr_wakeup_buffer.sv
`default_nettype none
// ============================================================================
// Module : srcopr_wakeup_buffer
// Brief  : RS-group operand store with broadcast wakeup, readiness and issue read.
// Rev    : 1.0
// ============================================================================
module srcopr_wakeup_buffer
   import srcopr_wakeup_buffer_pkg::*;
#(
   parameter int ENTRY_NUM = RS_ENTRY_NUM,
   parameter int ENTRY_SEL = RS_ENTRY_SEL,
   parameter int NUM_SRC   = RS_NUM_SRC,
   parameter int NUM_BCAST = RS_NUM_BCAST
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          we_i,
   input  logic [ENTRY_SEL-1:0]          wsel_i,
   input  logic [NUM_SRC*DATA_LEN-1:0]   wsrc_i,
   input  logic [NUM_SRC-1:0]            wrdy_i,
   input  logic [NUM_BCAST-1:0]          bcast_valid_i,
   input  logic [NUM_BCAST*RRF_SEL-1:0]  bcast_tag_i,
   input  logic [NUM_BCAST*DATA_LEN-1:0] bcast_data_i,
   input  logic                          issue_i,
   input  logic [ENTRY_SEL-1:0]          issue_sel_i,
   input  logic                          kill_i,
   output logic [ENTRY_NUM-1:0]          busy_o,
   output logic [ENTRY_NUM-1:0]          ready_o,
   output logic                          issue_valid_o,
   output logic [NUM_SRC*DATA_LEN-1:0]   issue_src_o
);

   operand_t                    w_opr [ENTRY_NUM][NUM_SRC];
   logic [ENTRY_NUM-1:0]        w_ready;
   logic                        w_issue_ok;
   logic [NUM_SRC*DATA_LEN-1:0] w_issue_data;

   logic [ENTRY_NUM-1:0]        busy_q;
   logic [ENTRY_NUM-1:0]        busy_d;
   logic                        issue_valid_q;
   logic                        issue_valid_d;
   logic [NUM_SRC*DATA_LEN-1:0] issue_src_q;
   logic [NUM_SRC*DATA_LEN-1:0] issue_src_d;

   for (genvar i = 0; i < ENTRY_NUM; i++) begin : g_entry
      for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
         srcopr_wakeup_slot #(
            .NUM_BCAST (NUM_BCAST)
         ) u_slot (
            .clk_i         (clk_i),
            .busy_i        (busy_q[i]),
            .we_i          (we_i && (wsel_i == ENTRY_SEL'(i))),
            .wdata_i       (wsrc_i[s*DATA_LEN +: DATA_LEN]),
            .wrdy_i        (wrdy_i[s]),
            .bcast_valid_i (bcast_valid_i),
            .bcast_tag_i   (bcast_tag_i),
            .bcast_data_i  (bcast_data_i),
            .opr_o         (w_opr[i][s])
         );
      end
   end

   // Readiness looks only at stored state, never at this cycle's broadcasts.
   always_comb begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
         w_ready[i] = busy_q[i];
         for (int s = 0; s < NUM_SRC; s++) begin
            w_ready[i] = w_ready[i] & w_opr[i][s].rdy;
         end
      end
   end

   always_comb begin
      w_issue_ok = issue_i & w_ready[issue_sel_i];
      for (int s = 0; s < NUM_SRC; s++) begin
         w_issue_data[s*DATA_LEN +: DATA_LEN] = w_opr[issue_sel_i][s].data;
      end
   end

   // Write is applied after issue-clear so a same-index write keeps the entry busy.
   always_comb begin
      busy_d        = busy_q;
      issue_valid_d = 1'b0;
      issue_src_d   = issue_src_q;
      if (w_issue_ok) begin
         busy_d[issue_sel_i] = 1'b0;
         issue_valid_d       = 1'b1;
         issue_src_d         = w_issue_data;
      end
      if (we_i) begin
         busy_d[wsel_i] = 1'b1;
      end
      if (kill_i) begin
         busy_d        = '0;
         issue_valid_d = 1'b0;
         issue_src_d   = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         busy_q        <= '0;
         issue_valid_q <= 1'b0;
         issue_src_q   <= '0;
      end else begin
         busy_q        <= busy_d;
         issue_valid_q <= issue_valid_d;
         issue_src_q   <= issue_src_d;
      end
   end

   assign busy_o        = busy_q;
   assign ready_o       = w_ready;
   assign issue_valid_o = issue_valid_q;
   assign issue_src_o   = issue_src_q;

endmodule : srcopr_wakeup_buffer
`default_nettype wire

// File: tb/tb_srcopr_wakeup_buffer.sv
`default_nettype none
// ============================================================================
// Module : tb_srcopr_wakeup_buffer
// Brief  : Directed plus random stimulus against an entry-level reference model.
// Rev    : 1.0
// ============================================================================
module tb_srcopr_wakeup_buffer;

   localparam int EN = 8;
   localparam int NS = 2;
   localparam int NB = 4;
   localparam int DL = 32;
   localparam int RS = 6;

   logic              clk_i = 1'b0;
   logic              reset_i, we_i, issue_i, kill_i;
   logic [2:0]        wsel_i, issue_sel_i;
   logic [NS*DL-1:0]  wsrc_i;
   logic [NS-1:0]     wrdy_i;
   logic [NB-1:0]     bcast_valid_i;
   logic [NB*RS-1:0]  bcast_tag_i;
   logic [NB*DL-1:0]  bcast_data_i;
   logic [EN-1:0]     busy_o, ready_o;
   logic              issue_valid_o;
   logic [NS*DL-1:0]  issue_src_o;

   always #5 clk_i = ~clk_i;

   srcopr_wakeup_buffer dut (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .we_i          (we_i),
      .wsel_i        (wsel_i),
      .wsrc_i        (wsrc_i),
      .wrdy_i        (wrdy_i),
      .bcast_valid_i (bcast_valid_i),
      .bcast_tag_i   (bcast_tag_i),
      .bcast_data_i  (bcast_data_i),
      .issue_i       (issue_i),
      .issue_sel_i   (issue_sel_i),
      .kill_i        (kill_i),
      .busy_o        (busy_o),
      .ready_o       (ready_o),
      .issue_valid_o (issue_valid_o),
      .issue_src_o   (issue_src_o)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: per-entry occupancy and per-source value/tag with ready flag.
   bit          m_busy [EN];
   bit          m_rdy  [EN][NS];
   logic [31:0] m_val  [EN][NS];
   logic [NS*DL-1:0] exp_hold = '0;
   logic [NS*DL-1:0] sbq [$];
   bit          mon_en = 1'b0;

   bit          s_we, s_issue, s_kill, s_reset;
   int          s_wsel, s_isel;
   logic [31:0] s_wsrc [NS];
   bit          s_wrdy [NS];
   bit          s_bv   [NB];
   logic [5:0]  s_btag [NB];
   logic [31:0] s_bdata[NB];

   function automatic bit m_ready(int i);
      bit r = m_busy[i];
      for (int s = 0; s < NS; s++) r = r & m_rdy[i][s];
      return r;
   endfunction

   task automatic bus_lookup(input logic [5:0] tag, output bit hit, output logic [31:0] d);
      hit = 1'b0;
      d   = '0;
      for (int k = 0; k < NB; k++) begin
         if (!hit && s_bv[k] && s_btag[k] == tag) begin
            hit = 1'b1;
            d   = s_bdata[k];
         end
      end
   endtask

   task automatic idle();
      s_we = 0; s_issue = 0; s_kill = 0; s_reset = 0; s_wsel = 0; s_isel = 0;
      for (int s = 0; s < NS; s++) begin s_wsrc[s] = '0; s_wrdy[s] = 0; end
      for (int k = 0; k < NB; k++) begin s_bv[k] = 0; s_btag[k] = '0; s_bdata[k] = '0; end
   endtask

   task automatic step();
      bit               legal, hit;
      logic [31:0]      d;
      logic [NS*DL-1:0] issued;
      bit               n_busy [EN];
      bit               n_rdy  [EN][NS];
      logic [31:0]      n_val  [EN][NS];
      @(negedge clk_i);
      reset_i = s_reset; kill_i = s_kill; we_i = s_we; issue_i = s_issue;
      wsel_i = 3'(s_wsel); issue_sel_i = 3'(s_isel);
      for (int s = 0; s < NS; s++) begin
         wsrc_i[s*DL +: DL] = s_wsrc[s];
         wrdy_i[s]          = s_wrdy[s];
      end
      for (int k = 0; k < NB; k++) begin
         bcast_valid_i[k]          = s_bv[k];
         bcast_tag_i[k*RS +: RS]   = s_btag[k];
         bcast_data_i[k*DL +: DL]  = s_bdata[k];
      end
      legal  = s_issue && !s_kill && !s_reset && m_ready(s_isel);
      issued = '0;
      for (int s = 0; s < NS; s++) issued[s*DL +: DL] = m_val[s_isel][s];
      n_busy = m_busy; n_rdy = m_rdy; n_val = m_val;
      for (int i = 0; i < EN; i++)
         for (int s = 0; s < NS; s++)
            if (m_busy[i] && !m_rdy[i][s]) begin
               bus_lookup(m_val[i][s][5:0], hit, d);
               if (hit) begin n_rdy[i][s] = 1; n_val[i][s] = d; end
            end
      if (legal) n_busy[s_isel] = 0;
      if (s_we) begin
         n_busy[s_wsel] = 1;
         for (int s = 0; s < NS; s++) begin
            bus_lookup(s_wsrc[s][5:0], hit, d);
            n_rdy[s_wsel][s] = s_wrdy[s] || hit;
            n_val[s_wsel][s] = (!s_wrdy[s] && hit) ? d : s_wsrc[s];
         end
      end
      if (s_kill || s_reset) for (int i = 0; i < EN; i++) n_busy[i] = 0;
      @(posedge clk_i);
      m_busy = n_busy; m_rdy = n_rdy; m_val = n_val;
      if (legal) begin sbq.push_back(issued); exp_hold = issued; end
      if (s_kill || s_reset) exp_hold = '0;
      mon_en = 1'b1;
   endtask

   task automatic rand_stim();
      int  rl[$];
      int  fl[$];
      bit  legal;
      idle();
      s_reset = ($urandom_range(0, 149) == 0);
      s_kill  = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 3) != 0) begin
         for (int i = 0; i < EN; i++) if (m_ready(i)) rl.push_back(i);
         s_issue = 1;
         if (rl.size() > 0 && $urandom_range(0, 4) != 0) s_isel = rl[$urandom_range(0, rl.size() - 1)];
         else s_isel = $urandom_range(0, EN - 1);
      end
      legal = s_issue && m_ready(s_isel);
      if ($urandom_range(0, 2) != 0) begin
         for (int i = 0; i < EN; i++) if (!m_busy[i] || (legal && i == s_isel)) fl.push_back(i);
         if (fl.size() > 0) begin
            s_we   = 1;
            s_wsel = fl[$urandom_range(0, fl.size() - 1)];
            for (int s = 0; s < NS; s++) begin
               s_wrdy[s] = ($urandom_range(0, 2) == 0);
               s_wsrc[s] = s_wrdy[s] ? $urandom : (($urandom & 32'hFFFF_FFC0) | 32'($urandom_range(0, 15)));
            end
         end
      end
      for (int k = 0; k < NB; k++) begin
         s_bv[k]    = ($urandom_range(0, 2) == 0);
         s_btag[k]  = 6'($urandom_range(0, 15));
         s_bdata[k] = $urandom;
      end
   endtask

   task automatic wr(int e, logic [31:0] v0, bit r0, logic [31:0] v1, bit r1);
      s_we = 1; s_wsel = e;
      s_wsrc[0] = v0; s_wrdy[0] = r0; s_wsrc[1] = v1; s_wrdy[1] = r1;
   endtask

   always @(negedge clk_i) begin
      logic [EN-1:0]    eb, er;
      logic [NS*DL-1:0] exp;
      if (mon_en) begin
         for (int i = 0; i < EN; i++) begin eb[i] = m_busy[i]; er[i] = m_ready(i); end
         checks++;
         if (busy_o !== eb) begin errors++; $display("FAIL busy got %b want %b", busy_o, eb); end
         checks++;
         if (ready_o !== er) begin errors++; $display("FAIL ready got %b want %b", ready_o, er); end
         if (issue_valid_o) begin
            checks++;
            if (sbq.size() == 0) begin
               errors++; $display("FAIL issue_valid got 1 want 0");
            end else begin
               exp = sbq.pop_front();
               if (issue_src_o !== exp) begin
                  errors++; $display("FAIL issue_src got %h want %h", issue_src_o, exp);
               end
            end
         end else begin
            if (sbq.size() != 0) begin
               checks++; errors++;
               $display("FAIL issue_valid got 0 want 1");
               void'(sbq.pop_front());
            end
            checks++;
            if (issue_src_o !== exp_hold) begin
               errors++; $display("FAIL issue_src_hold got %h want %h", issue_src_o, exp_hold);
            end
         end
      end
   end

   initial begin
      idle(); s_reset = 1; step(); step(); idle();
      // ready operands: write, observe, issue
      wr(2, 32'h11, 1, 32'h22, 1); step(); idle(); step();
      s_issue = 1; s_isel = 2; step(); idle(); step();
      // wakeup two cycles after dispatch, highest bus
      wr(0, 32'h5, 0, 32'h77, 1); step(); idle(); step();
      s_bv[3] = 1; s_btag[3] = 6'd5; s_bdata[3] = 32'hDEAD; step(); idle(); step();
      s_issue = 1; s_isel = 0; step(); idle(); step();
      // write-cycle bypass
      wr(1, 32'h9, 0, 32'hFFFF_FF49, 0);
      s_bv[1] = 1; s_btag[1] = 6'd9; s_bdata[1] = 32'h1234; step(); idle();
      s_issue = 1; s_isel = 1; step(); idle(); step();
      // one tag wakes two entries; ready value with matching low bits untouched
      wr(1, 32'hABCD_0007, 1, 32'h7, 0); step(); idle();
      wr(4, 32'h0000_1047, 1, 32'h1_0007, 0); step(); idle(); step();
      s_bv[0] = 1; s_btag[0] = 6'd7; s_bdata[0] = 32'hCAFE;
      s_bv[2] = 1; s_btag[2] = 6'd7; s_bdata[2] = 32'hBEEF; step(); idle(); step();
      s_issue = 1; s_isel = 1; step(); idle();
      s_issue = 1; s_isel = 4; step(); idle(); step();
      // issue and write the same index
      wr(3, 32'h33, 1, 32'h34, 1); step(); idle(); step();
      s_issue = 1; s_isel = 3; wr(3, 32'h55, 1, 32'h56, 1); step(); idle(); step();
      s_issue = 1; s_isel = 3; step(); idle(); step();
      // kill beats write and issue
      wr(5, 32'h1, 1, 32'h2, 1); step(); idle();
      wr(6, 32'h3, 1, 32'h4, 1); step(); idle();
      wr(7, 32'h5, 1, 32'h6, 1); step(); idle();
      s_kill = 1; s_issue = 1; s_isel = 5; wr(0, 32'h8, 1, 32'h9, 1); step(); idle(); step();
      // reset during a pending wakeup
      wr(2, 32'hC, 0, 32'h1, 1); step(); idle();
      s_reset = 1; s_bv[0] = 1; s_btag[0] = 6'd12; s_bdata[0] = 32'h99; step(); idle(); step();
      for (int n = 0; n < 1500; n++) begin
         rand_stim();
         step();
      end
      idle(); step(); step();
      @(negedge clk_i); #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_srcopr_wakeup_buffer
`default_nettype wire
